// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Captures a value on load, converts it to BCD by double-dabble (or uses it as hex), then scans the committed digits.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int CLK_HZ     = 50000000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            segments,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] anodes_n
);

  localparam int SLOT_RAW = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int P        = (SLOT_RAW < 1) ? 1 : SLOT_RAW;
  localparam int PW       = (P > 1) ? $clog2(P) : 1;
  localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_N    = (BIN_WIDTH + 2) / 3;
  localparam int BCD_D    = (BCD_N > NUM_DIGITS) ? BCD_N : NUM_DIGITS;
  localparam int BCD_BITS = 4 * BCD_D;
  localparam int DW       = 4 * NUM_DIGITS;
  localparam int HEX_W    = (BIN_WIDTH > DW) ? BIN_WIDTH : DW;
  localparam int CW       = $clog2(BIN_WIDTH + 1);
  localparam bit DEAD_EN  = (P > 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int k = 0; k < n; k++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

  localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);
  localparam logic [63:0] HEX_LIMIT = 64'd1 << DW;

  function automatic logic [BCD_BITS-1:0] dd_adjust(input logic [BCD_BITS-1:0] bcd);
    logic [BCD_BITS-1:0] res;
    res = bcd;
    for (int k = 0; k < BCD_D; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] nib, input logic is_hex);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = is_hex ? 7'b0001000 : SEG_BLANK;
      4'd11:   s = is_hex ? 7'b0000011 : SEG_BLANK;
      4'd12:   s = is_hex ? 7'b1000110 : SEG_BLANK;
      4'd13:   s = is_hex ? 7'b0100001 : SEG_BLANK;
      4'd14:   s = is_hex ? 7'b0000110 : SEG_BLANK;
      4'd15:   s = is_hex ? 7'b0001110 : SEG_BLANK;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_overflow;
  logic [BIN_WIDTH-1:0]  r_bin;
  logic [BCD_BITS-1:0]   r_bcd;
  logic [CW-1:0]         r_cnt;
  logic                  r_hex;
  logic [NUM_DIGITS-1:0] r_dp;
  logic                  r_ovf_cap;
  logic [DW-1:0]         r_disp;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic                  r_disp_hex;
  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [6:0]            r_segments;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_anodes_n;

  logic [63:0]           w_value_ext;
  logic [BCD_BITS-1:0]   w_bcd_adj;
  logic [HEX_W-1:0]      w_hex_ext;
  logic [DW-1:0]         w_commit_digits;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic [6:0]            w_seg_next;
  logic                  w_dp_n_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_value_ext     = 64'(value);
  assign w_bcd_adj       = dd_adjust(r_bcd);
  assign w_hex_ext       = HEX_W'(r_bin);
  assign w_commit_digits = r_hex ? w_hex_ext[DW-1:0] : r_bcd[DW-1:0];

  // Load/convert/commit sequencer; the display register only changes in COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_hex      <= 1'b0;
      r_dp       <= '0;
      r_ovf_cap  <= 1'b0;
      r_disp     <= '0;
      r_disp_dp  <= '0;
      r_disp_hex <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin     <= value;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_hex     <= hex_mode;
            r_dp      <= dp_in;
            r_ovf_cap <= hex_mode ? (w_value_ext >= HEX_LIMIT) : (w_value_ext >= DEC_LIMIT);
            if (hex_mode) begin
              r_state <= S_COMMIT;
            end else begin
              r_state <= S_CONVERT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CONVERT: begin
          r_bcd <= {w_bcd_adj[BCD_BITS-2:0], r_bin[BIN_WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(BIN_WIDTH - 1)) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_disp     <= w_commit_digits;
          r_disp_dp  <= r_dp;
          r_disp_hex <= r_hex;
          r_overflow <= r_ovf_cap;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(P - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // w_lz[i] marks digits with nothing but zeros at and above them; digit 0 always shows.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_disp[4*i +: 4] == 4'd0);
      w_lz[i]    = w_zero_run;
    end
    w_lz[0] = 1'b0;
  end

  assign w_nib    = r_disp[{r_idx, 2'b00} +: 4];
  assign w_dp_sel = r_disp_dp[r_idx];

  // Pin values for the current slot, including dead time at the start of each slot.
  always_comb begin
    w_seg_next  = SEG_BLANK;
    w_dp_n_next = 1'b1;
    if (r_overflow) begin
      w_seg_next  = SEG_DASH;
      w_dp_n_next = 1'b1;
    end else if (blank_lz && w_lz[r_idx]) begin
      w_seg_next  = SEG_BLANK;
      w_dp_n_next = ~w_dp_sel;
    end else begin
      w_seg_next  = seg7(w_nib, r_disp_hex);
      w_dp_n_next = ~w_dp_sel;
    end
    if (DEAD_EN && (r_presc == '0)) begin
      w_an_next = '1;
    end else begin
      w_an_next = ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  // Registered pin drivers, updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_segments <= SEG_BLANK;
      r_dp_n     <= 1'b1;
      r_anodes_n <= '1;
    end else begin
      r_segments <= w_seg_next;
      r_dp_n     <= w_dp_n_next;
      r_anodes_n <= w_an_next;
    end
  end

  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign segments = r_segments;
  assign dp_n     = r_dp_n;
  assign anodes_n = r_anodes_n;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with P = 5 (CLK_HZ=1000, REFRESH_HZ=50, 4 digits).
module tb_seven_seg_scan_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110, SF = 7'b0001110, SBL = 7'h7F, SDASH = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        busy;
  logic        overflow;
  logic [6:0]  segments;
  logic        dp_n;
  logic [3:0]  anodes_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [13:0]     value;
    logic            hex;
    logic            blank;
    logic [3:0]      dp;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
    logic            ovf;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .BIN_WIDTH(14), .CLK_HZ(1000), .REFRESH_HZ(50)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp_in(dp_in), .busy(busy), .overflow(overflow),
    .segments(segments), .dp_n(dp_n), .anodes_n(anodes_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic capture(output logic [3:0][6:0] seg, output logic [3:0] dpn, output logic [3:0] seen);
    logic [3:0] m;
    seen = '0;
    seg  = '1;
    dpn  = '1;
    for (int c = 0; c < 60 && seen != 4'hF; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        m = 4'b0001 << i;
        if (anodes_n == ~m) begin
          seg[i]  = segments;
          dpn[i]  = dp_n;
          seen[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
    logic [3:0]      seen;
    capture(seg, dpn, seen);
    chk({tag, " slots seen"}, 32'(seen), 32'hF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s seg slot%0d", tag, i), 32'(seg[i]), 32'(v.seg[i]));
      chk($sformatf("%s dp_n slot%0d", tag, i), 32'(dpn[i]), 32'(v.dpn[i]));
    end
    chk({tag, " overflow"}, 32'(overflow), 32'(v.ovf));
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, " busy released"}, 32'(busy), 32'd0);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    value    = v.value;
    hex_mode = v.hex;
    blank_lz = v.blank;
    dp_in    = v.dp;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle($sformatf("load %0h", v.value));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, " segments"}, 32'(segments), 32'(SBL));
    chk({tag, " dp_n"}, 32'(dp_n), 32'd1);
    chk({tag, " anodes_n"}, 32'(anodes_n), 32'hF);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int bc;
    int oldbad;
    int found;
    int presc;
    int idx;
    logic [3:0] exp_an;
    logic [3:0] prev;
    vec_t v42;
    vec_t vzero;

    tbl[0]  = '{14'd1234,  1'b0, 1'b0, 4'b0000, {S1, S2, S3, S4},         4'b1111, 1'b0};
    tbl[1]  = '{14'h02AF,  1'b1, 1'b1, 4'b0000, {SBL, S2, SA, SF},        4'b1111, 1'b0};
    tbl[2]  = '{14'd10000, 1'b0, 1'b0, 4'b1111, {SDASH, SDASH, SDASH, SDASH}, 4'b1111, 1'b1};
    tbl[3]  = '{14'd7,     1'b0, 1'b1, 4'b0000, {SBL, SBL, SBL, S7},      4'b1111, 1'b0};
    tbl[4]  = '{14'd5,     1'b0, 1'b0, 4'b0100, {S0, S0, S0, S5},         4'b1011, 1'b0};
    tbl[5]  = '{14'd5,     1'b0, 1'b1, 4'b0100, {SBL, SBL, SBL, S5},      4'b1011, 1'b0};
    tbl[6]  = '{14'd0,     1'b0, 1'b1, 4'b0000, {SBL, SBL, SBL, S0},      4'b1111, 1'b0};
    tbl[7]  = '{14'h3FFF,  1'b1, 1'b1, 4'b0001, {S3, SF, SF, SF},         4'b1110, 1'b0};
    tbl[8]  = '{14'd9999,  1'b0, 1'b1, 4'b0000, {S9, S9, S9, S9},         4'b1111, 1'b0};
    tbl[9]  = '{14'd16383, 1'b0, 1'b0, 4'b1111, {SDASH, SDASH, SDASH, SDASH}, 4'b1111, 1'b1};
    tbl[10] = '{14'h0B0C,  1'b1, 1'b1, 4'b1000, {SBL, SB, S0, SC},        4'b0111, 1'b0};
    tbl[11] = '{14'h00DE,  1'b1, 1'b0, 4'b0000, {S0, S0, SD, SE},         4'b1111, 1'b0};
    tbl[12] = '{14'd1000,  1'b0, 1'b1, 4'b0000, {S1, S0, S0, S0},         4'b1111, 1'b0};
    v42     = '{14'd42,    1'b0, 1'b0, 4'b0000, {S0, S0, S4, S2},         4'b1111, 1'b0};
    vzero   = '{14'd0,     1'b0, 1'b0, 4'b0000, {S0, S0, S0, S0},         4'b1111, 1'b0};

    // Reset, then the idle scan pattern against a slot model.
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    rst = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      presc  = (j - 1) % 5;
      idx    = ((j - 1) / 5) % 4;
      exp_an = (presc == 0) ? 4'hF : ~(4'b0001 << idx);
      chk($sformatf("idle anodes_n cyc%0d", j), 32'(anodes_n), 32'(exp_an));
      if (presc != 0) chk($sformatf("idle segments cyc%0d", j), 32'(segments), 32'(S0));
    end
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle overflow", 32'(overflow), 32'd0);

    // Decimal 1234: busy length and old digits held during conversion.
    @(negedge clk);
    value = 14'd1234; hex_mode = 1'b0; blank_lz = 1'b0; dp_in = 4'b0000; load = 1'b1;
    bc = 0; oldbad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (!busy) break;
      bc++;
      if (anodes_n != 4'hF && segments !== S0) oldbad++;
    end
    chk("1234 busy cycles", 32'(bc), 32'd15);
    chk("1234 old digits during busy", 32'(oldbad), 32'd0);
    repeat (2) @(negedge clk);
    check_frame(tbl[0], "dec 1234");

    // Hex 0x2AF: align to the first lit cycle of slot 0 and watch digit 0 switch.
    prev = anodes_n; found = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (prev == 4'hF && anodes_n == 4'b1110) begin
        found = 1;
        break;
      end
      prev = anodes_n;
    end
    chk("hex align found slot0", 32'(found), 32'd1);
    value = 14'h02AF; hex_mode = 1'b1; blank_lz = 1'b1; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("hex no busy", 32'(busy), 32'd0);
    chk("hex old digit edge0", 32'(segments), 32'(S4));
    @(negedge clk);
    chk("hex old digit edge1", 32'(segments), 32'(S4));
    chk("hex slot0 still lit", 32'(anodes_n), 32'b1110);
    @(negedge clk);
    chk("hex new digit edge2", 32'(segments), 32'(SF));
    repeat (2) @(negedge clk);
    check_frame(tbl[1], "hex 2AF");

    for (int i = 2; i < 13; i++) begin
      apply(tbl[i]);
      check_frame(tbl[i], $sformatf("vec%0d", i));
    end

    // Load 99 on the third busy cycle of a 42 conversion must be ignored.
    @(negedge clk);
    value = 14'd42; hex_mode = 1'b0; blank_lz = 1'b0; dp_in = 4'b0000; load = 1'b1;
    bc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (!busy) break;
      bc++;
      if (bc == 3) begin
        value = 14'd99;
        load  = 1'b1;
      end
    end
    chk("42 busy cycles with ignored load", 32'(bc), 32'd15);
    repeat (2) @(negedge clk);
    check_frame(v42, "ignored load");

    // Reset in the middle of a conversion aborts it and clears the display.
    @(negedge clk);
    value = 14'd1234; hex_mode = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid conversion busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_pins("mid reset");
    bc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("aborted conversion busy", 32'(bc), 32'd0);
    check_frame(vzero, "after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
